mv_row_feeder: RTL and testbench

Upstream stage of the 24-bit split-carry accumulator in the matrix-vector datapath. Accepts streamed signed 8-bit weight/activation pairs over a valid/ready handshake and forms registered 16-bit products. It sign-extends each product to 24 bits and drives the accumulator's operand and accumulate-enable, one product per cycle. At the end of each row it captures the accumulator's output and returns the row dot-product over a second valid/ready handshake, sequencing a configurable number of rows per job.

---
 rtl/mv_row_feeder_if.sv | 21 ++
 rtl/mv_row_feeder.sv | 138 +++++++++++++
 tb/tb_mv_row_feeder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mv_row_feeder_if.sv
// Operand stream (weight/activation pairs in) and row-result stream (dot-product out)
// of the matrix-vector row feeder, each a valid/ready handshake.
interface mv_row_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_w;
    logic [7:0]  in_x;
    logic        res_valid;
    logic        res_ready;
    logic [23:0] res_data;

    modport slave (
        input  in_valid, in_w, in_x, res_ready,
        output in_ready, res_valid, res_data
    );

    modport master (
        output in_valid, in_w, in_x, res_ready,
        input  in_ready, res_valid, res_data
    );
endinterface

// File: rtl/mv_row_feeder.sv
// Feeds signed 8x8 products into the 24-bit split-carry accumulator one column per cycle
// and returns each row's dot-product, sequencing n_rows rows per job.
module mv_row_feeder #(
    parameter int MAX_COLS = 128
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [7:0]         n_cols,
    input  logic [7:0]         n_rows,
    output logic [23:0]        acc_a,
    output logic               acc_aac,
    input  logic [23:0]        acc_out,
    output logic               busy,
    output logic               done,
    mv_row_feeder_if.slave     bus
);
    localparam int CW = $clog2(MAX_COLS);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN1, DRAIN2, OUT} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  col_cnt_q, col_cnt_d;
    logic [CW-1:0]  n_cols_m1_q, n_cols_m1_d;
    logic [7:0]     row_cnt_q, row_cnt_d;
    logic [7:0]     n_rows_m1_q, n_rows_m1_d;
    logic [23:0]    acc_a_q, acc_a_d;
    logic           acc_aac_q, acc_aac_d;
    logic [23:0]    res_data_q, res_data_d;
    logic           res_valid_q, res_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic               fire;
    logic signed [15:0] prod;

    // RUN is only ever occupied while col_cnt < n_cols, so readiness is the state itself.
    assign bus.in_ready = (state_q == RUN);
    assign fire         = bus.in_valid && bus.in_ready;
    assign prod         = $signed(bus.in_w) * $signed(bus.in_x);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        state_d     = state_q;
        col_cnt_d   = col_cnt_q;
        n_cols_m1_d = n_cols_m1_q;
        row_cnt_d   = row_cnt_q;
        n_rows_m1_d = n_rows_m1_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        // Bubbles add zero so the accumulator holds its running sum.
        acc_a_d     = '0;
        acc_aac_d   = 1'b1;

        if (fire) begin
            acc_a_d   = {{8{prod[15]}}, prod};
            acc_aac_d = (col_cnt_q != '0);
            col_cnt_d = col_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    n_cols_m1_d = (n_cols == 8'd0 || int'(n_cols) > MAX_COLS)
                                  ? CW'(MAX_COLS - 1) : CW'(n_cols - 8'd1);
                    // n_rows = 0 wraps to 255, i.e. a 256-row job.
                    n_rows_m1_d = n_rows - 8'd1;
                    col_cnt_d   = '0;
                    row_cnt_d   = '0;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (fire && col_cnt_q == n_cols_m1_q) state_d = DRAIN1;
            end
            DRAIN1: state_d = DRAIN2;
            DRAIN2: begin
                res_data_d  = acc_out;
                res_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    row_cnt_d   = row_cnt_q + 8'd1;
                    if (row_cnt_q == n_rows_m1_q) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        col_cnt_d = '0;
                        state_d   = RUN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            n_cols_m1_q <= '0;
            row_cnt_q   <= '0;
            n_rows_m1_q <= '0;
            acc_a_q     <= '0;
            acc_aac_q   <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_cnt_q   <= col_cnt_d;
            n_cols_m1_q <= n_cols_m1_d;
            row_cnt_q   <= row_cnt_d;
            n_rows_m1_q <= n_rows_m1_d;
            acc_a_q     <= acc_a_d;
            acc_aac_q   <= acc_aac_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign acc_a         = acc_a_q;
    assign acc_aac       = acc_aac_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_valid = res_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule

// File: tb/tb_mv_row_feeder.sv
// Directed bench for mv_row_feeder with a behavioural model of the downstream
// 24-bit accumulator closing the acc_a/acc_aac -> acc_out loop.
module tb_mv_row_feeder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  n_cols;
    logic [7:0]  n_rows;
    logic [23:0] acc_a;
    logic        acc_aac;
    logic [23:0] acc_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    mv_row_feeder_if bus ();

    mv_row_feeder #(.MAX_COLS(128)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .n_cols  (n_cols),
        .n_rows  (n_rows),
        .acc_a   (acc_a),
        .acc_aac (acc_aac),
        .acc_out (acc_out),
        .busy    (busy),
        .done    (done),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Accumulator model: result registered one cycle after its operand.
    always_ff @(posedge clk) acc_out <= acc_aac ? acc_out + acc_a : acc_a;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [7:0] w, input logic [7:0] x);
        bus.in_valid = 1'b1;
        bus.in_w     = w;
        bus.in_x     = x;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic begin_job(input logic [7:0] c, input logic [7:0] r);
        start  = 1'b1;
        n_cols = c;
        n_rows = r;
        step();
        start  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit exceeded");
    end

    initial begin
        logic [7:0] ws [3];
        logic [7:0] xs [3];
        int hs;

        ws[0] = 8'sd2;  xs[0] = 8'sd5;
        ws[1] = -8'sd3; xs[1] = 8'sd6;
        ws[2] = 8'sd4;  xs[2] = -8'sd7;

        reset_n = 1'b0; start = 1'b0; n_cols = '0; n_rows = '0;
        bus.in_valid = 1'b0; bus.in_w = '0; bus.in_x = '0; bus.res_ready = 1'b0;
        step(); step();
        check("rst_in_ready", 24'(bus.in_ready), 24'd0);
        check("rst_acc_a", acc_a, 24'd0);
        check("rst_acc_aac", 24'(acc_aac), 24'd0);
        check("rst_res_valid", 24'(bus.res_valid), 24'd0);
        check("rst_res_data", bus.res_data, 24'd0);
        check("rst_busy", 24'(busy), 24'd0);
        check("rst_done", 24'(done), 24'd0);
        reset_n = 1'b1;
        step();

        // Three-column row, continuous valid: 10 - 18 - 28 = -36.
        begin_job(8'd3, 8'd1);
        check("t1_busy", 24'(busy), 24'd1);
        check("t1_in_ready", 24'(bus.in_ready), 24'd1);
        pair(ws[0], xs[0]);
        check("t1_a0", acc_a, 24'd10);
        check("t1_aac0", 24'(acc_aac), 24'd0);
        pair(ws[1], xs[1]);
        check("t1_a1", acc_a, 24'hFFFFEE);
        check("t1_aac1", 24'(acc_aac), 24'd1);
        pair(ws[2], xs[2]);
        check("t1_a2", acc_a, 24'hFFFFE4);
        check("t1_aac2", 24'(acc_aac), 24'd1);
        check("t1_ready_drop", 24'(bus.in_ready), 24'd0);
        step();
        check("t1_valid_e1", 24'(bus.res_valid), 24'd0);
        check("t1_bubble_a", acc_a, 24'd0);
        step();
        check("t1_valid_e2", 24'(bus.res_valid), 24'd1);
        check("t1_data", bus.res_data, 24'hFFFFDC);
        check("t1_no_done", 24'(done), 24'd0);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t1_valid_clr", 24'(bus.res_valid), 24'd0);
        check("t1_done", 24'(done), 24'd1);
        check("t1_busy_clr", 24'(busy), 24'd0);
        step();
        check("t1_done_pulse", 24'(done), 24'd0);

        // n_cols = 0 saturates to 128 columns of 16384.
        begin_job(8'd0, 8'd1);
        bus.in_valid = 1'b1; bus.in_w = 8'h80; bus.in_x = 8'h80;
        hs = 0;
        for (int i = 0; i < 140; i++) begin
            if (bus.in_ready) hs++;
            step();
        end
        bus.in_valid = 1'b0;
        check("t2_handshakes", 24'(hs), 24'd128);
        check("t2_in_ready", 24'(bus.in_ready), 24'd0);
        check("t2_valid", 24'(bus.res_valid), 24'd1);
        check("t2_data", bus.res_data, 24'h200000);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t2_done", 24'(done), 24'd1);
        step();

        // Same row with four bubble cycles between pairs.
        begin_job(8'd3, 8'd1);
        for (int p = 0; p < 3; p++) begin
            pair(ws[p], xs[p]);
            if (p < 2) begin
                for (int k = 0; k < 4; k++) begin
                    step();
                    check("t3_bubble_a", acc_a, 24'd0);
                    check("t3_bubble_aac", 24'(acc_aac), 24'd1);
                end
            end
        end
        step(); step();
        check("t3_valid", 24'(bus.res_valid), 24'd1);
        check("t3_data", bus.res_data, 24'hFFFFDC);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t3_done", 24'(done), 24'd1);
        step();

        // Two rows, back-pressure on row 1, stray start while busy.
        begin_job(8'd2, 8'd2);
        pair(8'd1, 8'd1);
        pair(8'd1, 8'd1);
        step(); step();
        check("t4_r1_valid", 24'(bus.res_valid), 24'd1);
        check("t4_r1_data", bus.res_data, 24'd2);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                start = 1'b1; n_cols = 8'd7; n_rows = 8'd9;
            end else begin
                start = 1'b0;
            end
            step();
            check("t4_hold_data", bus.res_data, 24'd2);
            check("t4_hold_valid", 24'(bus.res_valid), 24'd1);
            check("t4_hold_ready", 24'(bus.in_ready), 24'd0);
        end
        start = 1'b0;
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t4_r1_clr", 24'(bus.res_valid), 24'd0);
        check("t4_r1_no_done", 24'(done), 24'd0);
        check("t4_r1_busy", 24'(busy), 24'd1);
        check("t4_r2_ready", 24'(bus.in_ready), 24'd1);
        pair(8'hFF, 8'd1);
        check("t4_r2_a0", acc_a, 24'hFFFFFF);
        check("t4_r2_aac0", 24'(acc_aac), 24'd0);
        pair(8'd0, 8'd0);
        check("t4_r2_aac1", 24'(acc_aac), 24'd1);
        check("t4_r2_ncols_kept", 24'(bus.in_ready), 24'd0);
        step(); step();
        check("t4_r2_data", bus.res_data, 24'hFFFFFF);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t4_done", 24'(done), 24'd1);
        check("t4_busy_clr", 24'(busy), 24'd0);
        step();

        // Reset mid-job, then a fresh one-column job.
        begin_job(8'd4, 8'd1);
        pair(8'd5, 8'd5);
        pair(8'd5, 8'd5);
        reset_n = 1'b0;
        #1;
        check("t5_in_ready", 24'(bus.in_ready), 24'd0);
        check("t5_acc_a", acc_a, 24'd0);
        check("t5_acc_aac", 24'(acc_aac), 24'd0);
        check("t5_busy", 24'(busy), 24'd0);
        check("t5_res_valid", 24'(bus.res_valid), 24'd0);
        step();
        reset_n = 1'b1;
        step();
        check("t5_idle", 24'(bus.in_ready), 24'd0);
        begin_job(8'd1, 8'd1);
        pair(8'd3, 8'd3);
        check("t5_a", acc_a, 24'd9);
        check("t5_aac", 24'(acc_aac), 24'd0);
        check("t5_drain", 24'(bus.in_ready), 24'd0);
        step(); step();
        check("t5_valid", 24'(bus.res_valid), 24'd1);
        check("t5_data", bus.res_data, 24'd9);
        bus.res_ready = 1'b1;
        step();
        bus.res_ready = 1'b0;
        check("t5_done", 24'(done), 24'd1);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
